// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector:
// overlap-mode encodings, default pattern settings and a small helper
// for the history fill counter.
package seq_det_pkg;

    localparam logic       MODE_NOOVL      = 1'b0;
    localparam logic       MODE_OVL        = 1'b1;
    localparam int         DEFAULT_PAT_W   = 4;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b0110;

    // Increment a fill count, saturating at the pattern length.
    function automatic int unsigned fill_step(input int unsigned fill, input int unsigned pat_w);
        fill_step = (fill >= pat_w) ? pat_w : fill + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Clear-priority saturating up-counter used for the detector's match count.
// Reset and clear both force zero; clear beats a simultaneous increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Count register: reset, then clear, then saturating increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign q = cnt_r;

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial sequence detector. Shifts qualified input bits into a
// history register, tracks how many of those bits are valid, and raises a
// registered one-cycle pulse when the full history equals the loaded pattern.
// Overlapping or non-overlapping matching is selectable each cycle.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             en,
    input  logic             ovl,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};

    logic [PAT_W-1:0]  pat_r;
    logic [PAT_W-1:0]  hist_r;
    logic [FILL_W-1:0] fill_r;
    logic              z_r;

    logic [PAT_W-1:0]  next_hist_s;
    logic [FILL_W-1:0] next_fill_s;
    logic              match_s;

    // Next history/fill and the match decision for the current edge.
    always_comb begin
        next_hist_s = {hist_r[PAT_W-2:0], x};
        next_fill_s = FILL_W'(fill_step(32'(fill_r), 32'(PAT_W)));
        match_s     = 1'b0;
        if (en && !pat_load) begin
            match_s = (next_fill_s == FILL_FULL) && (next_hist_s == pat_r);
        end else begin
            match_s = 1'b0;
        end
    end

    // Pattern, history, fill and match-pulse registers; load beats data.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r  <= PATTERN;
            hist_r <= {PAT_W{1'b0}};
            fill_r <= FILL_ZERO;
            z_r    <= 1'b0;
        end else if (pat_load) begin
            pat_r  <= pat_in;
            hist_r <= {PAT_W{1'b0}};
            fill_r <= FILL_ZERO;
            z_r    <= 1'b0;
        end else if (en) begin
            hist_r <= next_hist_s;
            // Non-overlap mode forgets the matched bits so a full new pattern is needed.
            fill_r <= (match_s && (ovl == MODE_NOOVL)) ? FILL_ZERO : next_fill_s;
            z_r    <= match_s;
        end else begin
            // Idle cycle: history is held, no pulse.
            z_r    <= 1'b0;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_s),
        .clr   (cnt_clr),
        .q     (match_cnt)
    );

    assign z = z_r;

endmodule
